sdram_line_cache: RTL

// - Direct-mapped read cache of 64-bit lines (4 x 16-bit words) between the CPU bus and the SDRAM controller.
// - Read hits are served in 2 clk_128 cycles with no SDRAM slot.
// - Misses fill a whole line from one 4-word SDRAM burst.
// - Writes are write-through, one 8 MHz slot each. A write that hits also updates the cached line (byte-merged).
// - Any slot without an issued request leaves ram_oe/ram_we low, so the controller refreshes in that slot.

---
 rtl/sdram_line_cache_if.sv | 26 ++
 rtl/sdram_line_cache.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sdram_line_cache_if.sv
// CPU-side request/response and SDRAM-controller-side signals of the line cache.
// slave = cache side, master = CPU/controller environment side.
interface sdram_line_cache_if;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_din;
    logic [1:0]  cpu_ds;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic [23:0] ram_addr;
    logic [15:0] ram_din;
    logic [1:0]  ram_ds;
    logic        ram_oe;
    logic        ram_we;
    logic [63:0] ram_dout;

    modport slave (
        input  cpu_addr, cpu_din, cpu_ds, cpu_rd, cpu_wr, ram_dout,
        output cpu_dout, cpu_ack, ram_addr, ram_din, ram_ds, ram_oe, ram_we
    );
    modport master (
        output cpu_addr, cpu_din, cpu_ds, cpu_rd, cpu_wr, ram_dout,
        input  cpu_dout, cpu_ack, ram_addr, ram_din, ram_ds, ram_oe, ram_we
    );
endinterface

// File: rtl/sdram_line_cache.sv
// Direct-mapped, write-through read cache of 4-word lines in front of the SDRAM controller.
// Optional hit/miss statistics counters: define LINE_CACHE_STATS_EN.
module sdram_line_cache #(
    parameter int LINES   = 16,
    parameter int INDEX_W = 4
) (
    input  logic                 clk_128,
    input  logic                 reset,
    input  logic                 clk_8_en,
    input  logic                 flush,
    sdram_line_cache_if.slave    bus,
    output logic [15:0]          hit_cnt,
    output logic [15:0]          miss_cnt
);
    localparam int TAG_W = 22 - INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT} state_t;

    state_t                         r_state, w_next;
    logic                           r_clk8_d;
    logic [23:0]                    r_addr;
    logic [15:0]                    r_din;
    logic [1:0]                     r_ds;
    logic                           r_is_wr;
    logic                           r_whit;
    logic                           r_ack;
    logic                           r_flush_pend;
    logic [LINES-1:0][63:0]         r_data;
    logic [LINES-1:0][TAG_W-1:0]    r_tag;
    logic [LINES-1:0]               r_valid;

    logic                           w_edge, w_hit, w_lat, w_ack, w_fill, w_rd_issue;
    logic                           w_wr_issue, w_wr_done, w_ret, w_clr, w_lookup_rd;
    logic [INDEX_W-1:0]             w_idx;
    logic [TAG_W-1:0]               w_tag;
    logic [5:0]                     w_off;

    assign w_edge = clk_8_en & ~r_clk8_d;
    assign w_idx  = r_addr[INDEX_W+1:2];
    assign w_tag  = r_addr[23:INDEX_W+2];
    assign w_off  = {r_addr[1:0], 4'b0000};
    // A flush in the lookup cycle must already turn the lookup into a miss.
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !flush;

    always_ff @(posedge clk_128) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if ((bus.cpu_wr || bus.cpu_rd) && !r_ack) w_next = LOOKUP;
            LOOKUP:   if (!r_is_wr)         w_next = w_hit ? IDLE : RD_ISSUE;
                      else                  w_next = (r_ds == 2'b00) ? IDLE : WR_ISSUE;
            RD_ISSUE: if (w_edge) w_next = RD_WAIT;
            RD_WAIT:  if (w_edge) w_next = IDLE;
            WR_ISSUE: if (w_edge) w_next = WR_WAIT;
            WR_WAIT:  if (w_edge) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_comb begin
        w_lat       = (r_state == IDLE) && (w_next == LOOKUP);
        w_lookup_rd = (r_state == LOOKUP) && !r_is_wr;
        w_rd_issue  = (r_state == RD_ISSUE) && w_edge;
        w_fill      = (r_state == RD_WAIT) && w_edge;
        w_wr_issue  = (r_state == WR_ISSUE) && w_edge;
        w_wr_done   = (r_state == WR_WAIT) && w_edge;
        w_ack       = ((r_state == LOOKUP) && (w_next == IDLE)) || w_fill || w_wr_done;
        w_ret       = w_fill || w_wr_done;
        w_clr       = (flush && ((r_state == IDLE) || (r_state == LOOKUP))) ||
                      ((flush || r_flush_pend) && w_ret);
    end

    always_ff @(posedge clk_128) begin
        if (reset) begin
            r_clk8_d     <= 1'b0;
            r_addr       <= '0;
            r_din        <= '0;
            r_ds         <= '0;
            r_is_wr      <= 1'b0;
            r_whit       <= 1'b0;
            r_ack        <= 1'b0;
            r_flush_pend <= 1'b0;
            bus.cpu_dout <= '0;
            bus.ram_addr <= '0;
            bus.ram_din  <= '0;
            bus.ram_ds   <= '0;
            bus.ram_oe   <= 1'b0;
            bus.ram_we   <= 1'b0;
        end else begin
            r_clk8_d <= clk_8_en;
            r_ack    <= w_ack;
            if (w_lat) begin
                r_addr  <= bus.cpu_addr;
                r_din   <= bus.cpu_din;
                r_ds    <= bus.cpu_ds;
                r_is_wr <= bus.cpu_wr;
            end
            if (r_state == LOOKUP) r_whit <= w_hit;
            if ((r_state == IDLE) || (r_state == LOOKUP) || w_ret) r_flush_pend <= 1'b0;
            else if (flush)                                        r_flush_pend <= 1'b1;
            if (w_lookup_rd && w_hit) bus.cpu_dout <= r_data[w_idx][w_off +: 16];
            if (w_fill)               bus.cpu_dout <= bus.ram_dout[w_off +: 16];
            if (w_rd_issue) begin
                bus.ram_oe   <= 1'b1;
                bus.ram_addr <= {r_addr[23:2], 2'b00};
                bus.ram_ds   <= 2'b11;
            end
            if (w_fill) bus.ram_oe <= 1'b0;
            if (w_wr_issue) begin
                bus.ram_we   <= 1'b1;
                bus.ram_addr <= r_addr;
                bus.ram_din  <= r_din;
                bus.ram_ds   <= r_ds;
            end
            if (w_wr_done) bus.ram_we <= 1'b0;
        end
    end

    assign bus.cpu_ack = r_ack;

    always_ff @(posedge clk_128) begin
        if (!reset) begin
            if (w_fill) begin
                r_data[w_idx] <= bus.ram_dout;
                r_tag[w_idx]  <= w_tag;
            end
            if (w_wr_done && r_whit) begin
                if (r_ds[0]) r_data[w_idx][w_off +: 8]         <= r_din[7:0];
                if (r_ds[1]) r_data[w_idx][w_off + 6'd8 +: 8]  <= r_din[15:8];
            end
        end
    end

    // A pending flush lands on the same edge as the fill's valid set and wins.
    always_ff @(posedge clk_128) begin
        if (reset)       r_valid <= '0;
        else if (w_clr)  r_valid <= '0;
        else if (w_fill) r_valid[w_idx] <= 1'b1;
    end

`ifdef LINE_CACHE_STATS_EN
    always_ff @(posedge clk_128) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (w_lookup_rd) begin
            if (w_hit && (hit_cnt != 16'hFFFF))    hit_cnt  <= hit_cnt + 16'd1;
            if (!w_hit && (miss_cnt != 16'hFFFF))  miss_cnt <= miss_cnt + 16'd1;
        end
    end
`else
    assign hit_cnt  = 16'h0000;
    assign miss_cnt = 16'h0000;
`endif
endmodule
